// File: rtl/sba_arbiter.sv
// rtl/sba_arbiter.sv - two-master round-robin bus arbiter with ack timeout
// m0 (CPU) and m1 (DMA) share one slave port; a hung slave is terminated with ack+err.
module sba_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_m0_stb,
  input  logic [31:0] i_m0_addr,
  input  logic [3:0]  i_m0_we,
  input  logic [31:0] i_m0_dat_w,
  output logic        o_m0_ack,
  output logic        o_m0_err,
  output logic [31:0] o_m0_dat_r,
  input  logic        i_m1_stb,
  input  logic [31:0] i_m1_addr,
  input  logic [3:0]  i_m1_we,
  input  logic [31:0] i_m1_dat_w,
  output logic        o_m1_ack,
  output logic        o_m1_err,
  output logic [31:0] o_m1_dat_r,
  output logic        o_stb,
  output logic [31:0] o_addr,
  output logic [3:0]  o_we,
  output logic [31:0] o_dat_w,
  input  logic        i_ack,
  input  logic [31:0] i_dat_r,
  output logic [1:0]  o_grant
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_OWN0 = 2'b01;
  localparam logic [1:0] S_OWN1 = 2'b10;
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  logic [1:0] state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_q, last_d;
  logic [7:0] cnt_q, cnt_d;

  logic own0, own1, own_stb, fin_ack, fin_to;

  assign own0    = (state_q == S_OWN0);
  assign own1    = (state_q == S_OWN1);
  assign own_stb = (own0 & i_m0_stb) | (own1 & i_m1_stb);
  // A dropped strobe is an abort: neither ack nor timeout is reported for it.
  assign fin_ack = own_stb & i_ack;
  assign fin_to  = own_stb & ~i_ack & (cnt_q == TO_LIMIT);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        // last_q = 1 means m1 owned last, so m0 wins a tie
        if (i_m0_stb && (!i_m1_stb || last_q)) begin
          state_d = S_OWN0;
          grant_d = 2'b01;
          cnt_d   = 8'd0;
        end else if (i_m1_stb) begin
          state_d = S_OWN1;
          grant_d = 2'b10;
          cnt_d   = 8'd0;
        end
      end
      default: begin
        if (!own_stb || fin_ack || fin_to) begin
          state_d = S_IDLE;
          grant_d = 2'b00;
          last_d  = own1;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_grant = grant_q;
  assign o_stb   = own_stb;
  assign o_addr  = own0 ? i_m0_addr  : (own1 ? i_m1_addr  : 32'd0);
  assign o_we    = own0 ? i_m0_we    : (own1 ? i_m1_we    : 4'd0);
  assign o_dat_w = own0 ? i_m0_dat_w : (own1 ? i_m1_dat_w : 32'd0);

  assign o_m0_ack   = own0 & (fin_ack | fin_to);
  assign o_m0_err   = own0 & fin_to;
  assign o_m0_dat_r = (own0 && !fin_to) ? i_dat_r : 32'd0;
  assign o_m1_ack   = own1 & (fin_ack | fin_to);
  assign o_m1_err   = own1 & fin_to;
  assign o_m1_dat_r = (own1 && !fin_to) ? i_dat_r : 32'd0;

endmodule
